scoreboard_hazard: RTL and testbench
====================================

SCOREBOARD_HAZARD -- requirements
Module: scoreboard_hazard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers.
REQ-002 Parameter IDXW, default `RFIDX_WIDTH (5): register index width.
REQ-003 Parameter MAXLAT, default 4: maximum result latency in cycles; legal range 1..15.
REQ-004 Parameter LATW, default 4: width of latency fields.
REQ-005 The design SHALL use one clock, clk; reset is reset_n, asynchronous and active-low.
REQ-006 The port list SHALL be as follows:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode holds an instruction requesting issue.
- issue_rd  in  IDXW  destination register.
- issue_wen  in  1  instruction writes issue_rd.
- issue_lat  in  LATW  cycles from issue to writeback-bus result.
- issue_rs1, issue_rs2  in  IDXW  source registers.
- issue_use_rs1, issue_use_rs2  in  1  source is actually read.
- kill  in  1  discard all in-flight operations (trap/full flush).
- stall  out  1  issue must not proceed this cycle.
- byp_rs1, byp_rs2  out  1  source is taken from the writeback bus this cycle.
- wb_valid  out  1  a tracked result is due on the writeback bus this cycle.
- wb_rd  out  IDXW  register written this cycle.
- busy  out  1  any operation is in flight.

Function
REQ-007 The block SHALL hold a per-register countdown cnt[r] (LATW bits), a writeback reservation vector resv[0..MAXLAT-1] and a parallel rd queue rdq[0..MAXLAT-1].
REQ-008 Effective latency L SHALL be issue_lat, with 0 treated as 1 and values above MAXLAT clamped to MAXLAT.
REQ-009 A write SHALL be tracked only if issue_wen=1 and issue_rd!=0; x0 is never pending.
REQ-010 Signal accept SHALL be issue_valid & ~stall & ~kill.
REQ-011 stall SHALL equal issue_valid & (RAW1 | RAW2 | WAW | PORT), combinational from registered state and the issue inputs:
- RAW1/RAW2: the used source is nonzero and has cnt >= 2.
- WAW: a tracked write whose rd has cnt > L.
- PORT: a tracked write with L < MAXLAT and resv[L]=1.
REQ-012 byp_rsN SHALL be 1 iff issue_use_rsN=1, issue_rsN!=0 and cnt[issue_rsN]==1; it is independent of issue_valid.
REQ-013 wb_valid SHALL equal resv[0]; wb_rd SHALL equal rdq[0] when wb_valid=1, else 0.
REQ-014 Each clock edge SHALL update state as follows:
- Every nonzero cnt decrements by 1.
- resv and rdq shift down one position; the top entry fills with 0.
- On accept of a tracked write: cnt[rd] <= L, resv[L-1] <= 1, rdq[L-1] <= rd; the new value overrides the decrement.
REQ-015 Timing: an op accepted in cycle c SHALL give wb_valid=1 and wb_rd=rd in cycle c+L; a consumer issuing in cycle c+L sees byp=1 and no stall; from cycle c+L+1 onward cnt=0 and the value is read from the register file.
REQ-016 kill=1 SHALL clear all cnt, resv and rdq at the next edge; kill takes priority over a simultaneous accept, so that issue is not recorded.
REQ-017 busy SHALL equal the OR of resv.
REQ-018 When issue_valid=0, stall SHALL be 0 and state SHALL only advance per REQ-014.

Reset
REQ-019 While reset_n=0: all cnt, resv and rdq are 0, and stall, byp_rs1, byp_rs2, wb_valid, wb_rd and busy are 0.
REQ-020 Reset asserted mid-operation SHALL drop all in-flight operations immediately; no wb_valid is produced after release for pre-reset issues.

Structure
REQ-021 `RFIDX_WIDTH and the MAXLAT default SHALL live in xgriscv_defines.v.
REQ-022 The resv/rdq shift structure SHALL be one sub-module, wb_resv_pipe, parameterised by MAXLAT and IDXW, with inputs set, set_lat and set_rd, and outputs resv and head.

Verification (MAXLAT=4)
REQ-023 Reset: hold reset_n=0 with random inputs -> all outputs 0; after release with issue_valid=0 -> busy=0.
REQ-024 RAW: cycle0 issue rd=5 lat=3; cycles 1-3 issue use_rs1, rs1=5 -> stall=1 in cycles 1-2; cycle3 stall=0, byp_rs1=1, wb_valid=1, wb_rd=5.
REQ-025 Port conflict: cycle0 rd=6 lat=3 accepted; cycle1 rd=7 lat=2 -> stall=1; cycle2 same request -> accepted; wb_rd=6 in cycle3, wb_rd=7 in cycle4.
REQ-026 WAW: cycle0 rd=8 lat=4; cycle1 rd=8 lat=1 -> stall in cycles 1-3; accepted in cycle4, where wb_rd=8 from the first op; wb_rd=8 again in cycle5.
REQ-027 x0/clamp: issue rd=0 lat=9, then use rs1=0 -> no stall, wb_valid stays 0; issue rd=3 lat=0 -> wb_rd=3 exactly one cycle later.
REQ-028 Kill: cycle0 rd=9 lat=4; cycle1 kill=1 with issue rd=10 lat=1 -> busy=0 from cycle2, no wb_valid for 9 or 10.

Source files
------------

// File: rtl/scoreboard_hazard_pkg.sv
// ============================================================================
// Module   : scoreboard_hazard_pkg
// Purpose  : constants and latency helper shared by the hazard scoreboard
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`include "xgriscv_defines.v"

package scoreboard_hazard_pkg;

    localparam int c_RFIDX_WIDTH    = `RFIDX_WIDTH;
    localparam int c_MAXLAT_DEFAULT = `SB_MAXLAT;
    localparam int c_NREG_DEFAULT   = 32;
    localparam int c_LATW_DEFAULT   = 4;

    // A zero latency still needs one cycle to reach the writeback bus.
    function automatic int eff_lat(input int lat, input int maxlat);
        if (lat == 0)      return 1;
        if (lat > maxlat)  return maxlat;
        return lat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scoreboard_hazard_wb_resv_pipe.sv
// ============================================================================
// Module   : wb_resv_pipe
// Purpose  : writeback-slot reservation shift register with parallel rd queue
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_resv_pipe #(
    parameter int MAXLAT = 4,
    parameter int IDXW   = 5,
    parameter int LATW   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              set,
    input  logic [LATW-1:0]   set_lat,
    input  logic [IDXW-1:0]   set_rd,
    output logic [MAXLAT-1:0] resv,
    output logic [IDXW-1:0]   head
);

    logic [MAXLAT-1:0] r_resv;
    logic [IDXW-1:0]   r_rdq   [MAXLAT];
    logic [MAXLAT-1:0] w_nxt_resv;
    logic [IDXW-1:0]   w_nxt_rdq [MAXLAT];

    // Slot set_lat-1 is written after the shift, so a new entry lands exactly L edges from head.
    for (genvar i = 0; i < MAXLAT; i++) begin : g_slot
        logic w_hit;
        assign w_hit = set && (set_lat == LATW'(i + 1));
        if (i == MAXLAT - 1) begin : g_top
            assign w_nxt_resv[i] = w_hit;
            assign w_nxt_rdq[i]  = w_hit ? set_rd : '0;
        end else begin : g_mid
            assign w_nxt_resv[i] = w_hit ? 1'b1   : r_resv[i+1];
            assign w_nxt_rdq[i]  = w_hit ? set_rd : r_rdq[i+1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resv <= '0;
            for (int i = 0; i < MAXLAT; i++) r_rdq[i] <= '0;
        end else if (clear) begin
            r_resv <= '0;
            for (int i = 0; i < MAXLAT; i++) r_rdq[i] <= '0;
        end else begin
            r_resv <= w_nxt_resv;
            for (int i = 0; i < MAXLAT; i++) r_rdq[i] <= w_nxt_rdq[i];
        end
    end

    assign resv = r_resv;
    assign head = r_rdq[0];

endmodule

`default_nettype wire

// File: rtl/xgriscv_defines.v
// Shared core-wide widths and defaults for the integer pipeline.
`ifndef XGRISCV_DEFINES_V
`define XGRISCV_DEFINES_V
`define RFIDX_WIDTH 5
`define SB_MAXLAT   4
`endif

// File: rtl/scoreboard_hazard.sv
// ============================================================================
// Module   : scoreboard_hazard
// Purpose  : issue-stage RAW/WAW/writeback-port hazard scoreboard with bypass
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`include "xgriscv_defines.v"

module scoreboard_hazard
    import scoreboard_hazard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int IDXW   = `RFIDX_WIDTH,
    parameter int MAXLAT = `SB_MAXLAT,
    parameter int LATW   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            issue_valid,
    input  logic [IDXW-1:0] issue_rd,
    input  logic            issue_wen,
    input  logic [LATW-1:0] issue_lat,
    input  logic [IDXW-1:0] issue_rs1,
    input  logic [IDXW-1:0] issue_rs2,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    input  logic            kill,
    output logic            stall,
    output logic            byp_rs1,
    output logic            byp_rs2,
    output logic            wb_valid,
    output logic [IDXW-1:0] wb_rd,
    output logic            busy
);

    logic [LATW-1:0]   r_cnt [NREG];
    logic [MAXLAT-1:0] w_resv;
    logic [IDXW-1:0]   w_head;
    logic [LATW-1:0]   w_lat;
    logic              w_tracked;
    logic              w_raw1;
    logic              w_raw2;
    logic              w_waw;
    logic              w_port;
    logic              w_slot_taken;
    logic              w_accept;
    logic              w_set;

    assign w_lat     = LATW'(eff_lat(int'(issue_lat), MAXLAT));
    assign w_tracked = issue_wen && (issue_rd != '0);

    assign w_raw1 = issue_use_rs1 && (issue_rs1 != '0) && (r_cnt[issue_rs1] >= LATW'(2));
    assign w_raw2 = issue_use_rs2 && (issue_rs2 != '0) && (r_cnt[issue_rs2] >= LATW'(2));
    assign w_waw  = w_tracked && (r_cnt[issue_rd] > w_lat);

    // Slot L is where an op issued earlier would already be landing in the same cycle.
    always_comb begin
        w_slot_taken = 1'b0;
        for (int i = 1; i < MAXLAT; i++) begin
            if (w_lat == LATW'(i)) w_slot_taken = w_resv[i];
        end
    end
    assign w_port = w_tracked && w_slot_taken;

    assign stall    = issue_valid && (w_raw1 || w_raw2 || w_waw || w_port);
    assign w_accept = issue_valid && !stall && !kill;
    assign w_set    = w_accept && w_tracked;

    assign byp_rs1 = issue_use_rs1 && (issue_rs1 != '0) && (r_cnt[issue_rs1] == LATW'(1));
    assign byp_rs2 = issue_use_rs2 && (issue_rs2 != '0) && (r_cnt[issue_rs2] == LATW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (kill || r == 0)
                    r_cnt[r] <= '0;
                else if (w_set && issue_rd == IDXW'(r))
                    r_cnt[r] <= w_lat;
                else if (r_cnt[r] != '0)
                    r_cnt[r] <= r_cnt[r] - LATW'(1);
            end
        end
    end

    wb_resv_pipe #(
        .MAXLAT (MAXLAT),
        .IDXW   (IDXW),
        .LATW   (LATW)
    ) u_resv_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (kill),
        .set     (w_set),
        .set_lat (w_lat),
        .set_rd  (issue_rd),
        .resv    (w_resv),
        .head    (w_head)
    );

    assign wb_valid = w_resv[0];
    assign wb_rd    = w_resv[0] ? w_head : '0;
    assign busy     = |w_resv;

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_hazard.sv
// ============================================================================
// Module   : tb_scoreboard_hazard
// Purpose  : directed vector bench for the hazard scoreboard (MAXLAT=4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scoreboard_hazard;

    logic       clk;
    logic       reset_n;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_wen;
    logic [3:0] issue_lat;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       issue_use_rs1;
    logic       issue_use_rs2;
    logic       kill;
    logic       stall;
    logic       byp_rs1;
    logic       byp_rs2;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       busy;

    int total;
    int bad;

    scoreboard_hazard #(
        .NREG   (32),
        .IDXW   (5),
        .MAXLAT (4),
        .LATW   (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_wen     (issue_wen),
        .issue_lat     (issue_lat),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .kill          (kill),
        .stall         (stall),
        .byp_rs1       (byp_rs1),
        .byp_rs2       (byp_rs2),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wen;
        logic [3:0] lat;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       k;
        logic       e_stall;
        logic       e_b1;
        logic       e_b2;
        logic       e_wbv;
        logic [4:0] e_wbrd;
        logic       e_busy;
    } vec_t;

    localparam int c_NVEC = 36;
    vec_t tbl [c_NVEC];

    function automatic vec_t mk(input logic v, input int rd, input logic wen, input int lat,
                                input int rs1, input logic u1, input int rs2, input logic u2,
                                input logic k, input logic s, input logic b1, input logic b2,
                                input logic wv, input int wrd, input logic bz);
        vec_t t;
        t.v = v;        t.rd = 5'(rd);   t.wen = wen;     t.lat = 4'(lat);
        t.rs1 = 5'(rs1); t.u1 = u1;      t.rs2 = 5'(rs2); t.u2 = u2;
        t.k = k;        t.e_stall = s;   t.e_b1 = b1;     t.e_b2 = b2;
        t.e_wbv = wv;   t.e_wbrd = 5'(wrd); t.e_busy = bz;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d want %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm, input int idx);
        chk({nm, ".stall"}, idx, 5'(stall), 5'd0);
        chk({nm, ".byp1"},  idx, 5'(byp_rs1), 5'd0);
        chk({nm, ".byp2"},  idx, 5'(byp_rs2), 5'd0);
        chk({nm, ".wbv"},   idx, 5'(wb_valid), 5'd0);
        chk({nm, ".wbrd"},  idx, wb_rd, 5'd0);
        chk({nm, ".busy"},  idx, 5'(busy), 5'd0);
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0; issue_wen = 0; issue_lat = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; kill = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        idle_inputs();

        //            v rd w lat rs1 u1 rs2 u2 k | st b1 b2 wv wrd bz
        // RAW on rs1
        tbl[0]  = mk(1, 5,1,3,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[1]  = mk(1, 0,0,0,  5,1, 0,0, 0,  1,0,0, 0,0, 1);
        tbl[2]  = mk(1, 0,0,0,  5,1, 0,0, 0,  1,0,0, 0,0, 1);
        tbl[3]  = mk(1, 0,0,0,  5,1, 0,0, 0,  0,1,0, 1,5, 1);
        tbl[4]  = mk(0, 0,0,0,  5,1, 0,0, 0,  0,0,0, 0,0, 0);
        // writeback port conflict
        tbl[5]  = mk(1, 6,1,3,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[6]  = mk(1, 7,1,2,  0,0, 0,0, 0,  1,0,0, 0,0, 1);
        tbl[7]  = mk(1, 7,1,2,  0,0, 0,0, 0,  0,0,0, 0,0, 1);
        tbl[8]  = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 1,6, 1);
        tbl[9]  = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 1,7, 1);
        tbl[10] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        // WAW
        tbl[11] = mk(1, 8,1,4,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[12] = mk(1, 8,1,1,  0,0, 0,0, 0,  1,0,0, 0,0, 1);
        tbl[13] = mk(1, 8,1,1,  0,0, 0,0, 0,  1,0,0, 0,0, 1);
        tbl[14] = mk(1, 8,1,1,  0,0, 0,0, 0,  1,0,0, 0,0, 1);
        tbl[15] = mk(1, 8,1,1,  0,0, 0,0, 0,  0,0,0, 1,8, 1);
        tbl[16] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 1,8, 1);
        tbl[17] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        // x0 never pending, zero latency becomes one
        tbl[18] = mk(1, 0,1,9,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[19] = mk(1, 0,0,0,  0,1, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[20] = mk(1, 3,1,0,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[21] = mk(0, 0,0,0,  0,0, 3,1, 0,  0,0,1, 1,3, 1);
        tbl[22] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        // latency above MAXLAT clamps to 4; RAW on rs2; no stall when idle
        tbl[23] = mk(1, 4,1,15, 0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[24] = mk(1, 0,0,0,  0,0, 4,1, 0,  1,0,0, 0,0, 1);
        tbl[25] = mk(0, 0,0,0,  0,0, 4,1, 0,  0,0,0, 0,0, 1);
        tbl[26] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 0,0, 1);
        tbl[27] = mk(0, 0,0,0,  4,1, 0,0, 0,  0,1,0, 1,4, 1);
        tbl[28] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        // kill beats a simultaneous issue
        tbl[29] = mk(1, 9,1,4,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[30] = mk(1,10,1,1,  0,0, 0,0, 1,  0,0,0, 0,0, 1);
        tbl[31] = mk(1, 0,0,0, 10,1, 9,1, 0,  0,0,0, 0,0, 0);
        tbl[32] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[33] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[34] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 0,0, 0);
        tbl[35] = mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0, 0,0, 0);

        // Reset held with random inputs: every output stays 0.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            issue_valid   = 1'($urandom);
            issue_rd      = 5'($urandom);
            issue_wen     = 1'($urandom);
            issue_lat     = 4'($urandom);
            issue_rs1     = 5'($urandom);
            issue_rs2     = 5'($urandom);
            issue_use_rs1 = 1'($urandom);
            issue_use_rs2 = 1'($urandom);
            kill          = 1'($urandom);
            #3;
            chk_all_zero("rst", c);
        end
        @(posedge clk); #1;
        idle_inputs();
        reset_n = 1'b1;
        #3;
        chk("post_rst.busy", 0, 5'(busy), 5'd0);
        chk("post_rst.wbv",  0, 5'(wb_valid), 5'd0);
        @(posedge clk); #1;

        for (int i = 0; i < c_NVEC; i++) begin
            issue_valid   = tbl[i].v;
            issue_rd      = tbl[i].rd;
            issue_wen     = tbl[i].wen;
            issue_lat     = tbl[i].lat;
            issue_rs1     = tbl[i].rs1;
            issue_rs2     = tbl[i].rs2;
            issue_use_rs1 = tbl[i].u1;
            issue_use_rs2 = tbl[i].u2;
            kill          = tbl[i].k;
            #3;
            chk("stall", i, 5'(stall),    5'(tbl[i].e_stall));
            chk("byp1",  i, 5'(byp_rs1),  5'(tbl[i].e_b1));
            chk("byp2",  i, 5'(byp_rs2),  5'(tbl[i].e_b2));
            chk("wbv",   i, 5'(wb_valid), 5'(tbl[i].e_wbv));
            chk("wbrd",  i, wb_rd,        tbl[i].e_wbrd);
            chk("busy",  i, 5'(busy),     5'(tbl[i].e_busy));
            @(posedge clk); #1;
        end

        // Reset mid-operation drops the in-flight op immediately and for good.
        idle_inputs();
        issue_valid = 1; issue_rd = 5'd11; issue_wen = 1; issue_lat = 4'd4;
        #3;
        chk("midrst.accept", 0, 5'(stall), 5'd0);
        @(posedge clk); #1;
        idle_inputs();
        #3;
        chk("midrst.busy_before", 0, 5'(busy), 5'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst.busy_now", 0, 5'(busy), 5'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            issue_use_rs1 = 1; issue_rs1 = 5'd11;
            #3;
            chk("midrst.wbv",  c, 5'(wb_valid), 5'd0);
            chk("midrst.byp1", c, 5'(byp_rs1),  5'd0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
